// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised accumulator CPU.
// Opcodes, state encoding and instruction field positions.
package cpu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_BUN = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SZA = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_INDIRECT = 2'd1,
        ST_EXEC     = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    // Indirect flag is the word MSB; opcode sits just below it.
    function automatic int i_bit(input int dw);
        return dw - 1;
    endfunction

    function automatic int op_msb(input int dw);
        return dw - 2;
    endfunction

    function automatic int op_lsb(input int dw);
        return dw - 4;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the accumulator CPU.
// Produces the new AC value and carry for ADD/SUB/AND/LDA.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] m,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, acc} + {1'b0, m};
    assign diff = {1'b0, acc} + {1'b0, ~m} + (DATA_W+1)'(1);

    // Select result per opcode; carry only meaningful for ADD/SUB
    always_comb begin
        result = acc;
        carry  = 1'b0;
        case (op)
            OP_ADD: {carry, result} = sum;
            OP_SUB: {carry, result} = diff;
            OP_AND: result = acc & m;
            OP_LDA: result = m;
            default: begin
                result = acc;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_acc_param.sv
// Parametrised accumulator CPU core.
// Fetch / optional indirect / execute sequencing on a single-port memory.
module cpu_acc_param
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              read,
    output logic              write,
    input  logic [DATA_W-1:0] memoryOut,
    output logic [DATA_W-1:0] memoryIn,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] ac,
    output logic              e,
    output logic              halted
);

    localparam int IB  = i_bit(DATA_W);
    localparam int OPH = op_msb(DATA_W);
    localparam int OPL = op_lsb(DATA_W);
    localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

    if (DATA_W < ADDR_W + 4) begin : g_width_chk
        $error("cpu_acc_param: DATA_W must be >= ADDR_W+4");
    end

    state_t            state;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] ac_q;
    logic              e_q;

    logic [2:0]        op;
    logic              ind;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;

    assign op  = ir[OPH:OPL];
    assign ind = ir[IB];
    assign ea  = ind ? ar : ir[ADDR_W-1:0];

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op),
        .acc    (ac_q),
        .m      (memoryOut),
        .result (alu_res),
        .carry  (alu_c)
    );

    // Memory strobes and address decoded from state; reset overrides
    always_comb begin
        read    = 1'b0;
        write   = 1'b0;
        address = pc;
        unique case (state)
            ST_FETCH: begin
                read    = 1'b1;
                address = pc;
            end
            ST_INDIRECT: begin
                read    = 1'b1;
                address = ir[ADDR_W-1:0];
            end
            ST_EXEC: begin
                address = ea;
                read    = (op == OP_ADD) || (op == OP_AND) ||
                          (op == OP_LDA) || (op == OP_SUB);
                write   = (op == OP_STA);
            end
            ST_HALTED: begin
                address = pc;
            end
        endcase
        if (reset) begin
            read    = 1'b1;
            write   = 1'b0;
            address = PC0;
        end
    end

    assign memoryIn = reset ? '0 : ac_q;
    assign ac       = ac_q;
    assign e        = e_q;
    assign halted   = (state == ST_HALTED) && !reset;

    // Instruction sequencer and architectural state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
            pc    <= PC0;
            ir    <= '0;
            ar    <= '0;
            ac_q  <= '0;
            e_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    ir    <= memoryOut;
                    pc    <= pc + ADDR_W'(1);
                    state <= memoryOut[IB] ? ST_INDIRECT : ST_EXEC;
                end
                ST_INDIRECT: begin
                    ar    <= memoryOut[ADDR_W-1:0];
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    case (op)
                        OP_ADD, OP_SUB: begin
                            ac_q <= alu_res;
                            e_q  <= alu_c;
                        end
                        OP_AND, OP_LDA: ac_q <= alu_res;
                        OP_BUN: pc <= ea;
                        OP_SZA: begin
                            if (ac_q == '0)
                                pc <= pc + ADDR_W'(1);
                        end
                        OP_HLT: state <= ST_HALTED;
                        default: ;
                    endcase
                end
                ST_HALTED: state <= ST_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_acc_param.sv
// Directed-program bench for cpu_acc_param.
// Default 8/4 instance plus a 12/8 instance with RESET_PC=254.
module tb_cpu_acc_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Default-width instance
    logic       reset1 = 1'b1;
    logic       rd1, wr1, e1, h1;
    logic [7:0] mout1, min1, ac1;
    logic [3:0] addr1;
    logic [7:0] mem1 [16];
    logic [7:0] img1 [16];
    logic       load1 = 1'b0;

    cpu_acc_param u_dut1 (
        .clk       (clk),
        .reset     (reset1),
        .read      (rd1),
        .write     (wr1),
        .memoryOut (mout1),
        .memoryIn  (min1),
        .address   (addr1),
        .ac        (ac1),
        .e         (e1),
        .halted    (h1)
    );

    assign mout1 = mem1[addr1];

    always @(posedge clk) begin
        if (load1) mem1 <= img1;
        else if (wr1) mem1[addr1] <= min1;
    end

    // Wide instance
    logic        reset2 = 1'b1;
    logic        rd2, wr2, e2, h2;
    logic [11:0] mout2, min2, ac2;
    logic [7:0]  addr2;
    logic [11:0] mem2 [256];
    logic [11:0] img2 [256];
    logic        load2 = 1'b0;

    cpu_acc_param #(
        .DATA_W   (12),
        .ADDR_W   (8),
        .RESET_PC (254)
    ) u_dut2 (
        .clk       (clk),
        .reset     (reset2),
        .read      (rd2),
        .write     (wr2),
        .memoryOut (mout2),
        .memoryIn  (min2),
        .address   (addr2),
        .ac        (ac2),
        .e         (e2),
        .halted    (h2)
    );

    assign mout2 = mem2[addr2];

    always @(posedge clk) begin
        if (load2) mem2 <= img2;
        else if (wr2) mem2[addr2] <= min2;
    end

    task automatic clear1();
        for (int i = 0; i < 16; i++) img1[i] = 8'h00;
    endtask

    task automatic start1();
        reset1 = 1'b1;
        load1  = 1'b1;
        @(posedge clk);
        #1 load1 = 1'b0;
        @(negedge clk);
        reset1 = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (rd1 !== 1'b1) begin fails++; $display("FAIL rst_read got %b want 1", rd1); end
        tests++; if (wr1 !== 1'b0) begin fails++; $display("FAIL rst_write got %b want 0", wr1); end
        tests++; if (addr1 !== 4'd0) begin fails++; $display("FAIL rst_addr got %h want 0", addr1); end
        tests++; if (min1 !== 8'h00) begin fails++; $display("FAIL rst_min got %h want 00", min1); end
        tests++; if (h1 !== 1'b0) begin fails++; $display("FAIL rst_halted got %b want 0", h1); end
        tests++; if (ac1 !== 8'h00 || e1 !== 1'b0) begin fails++; $display("FAIL rst_ac_e got %h/%b want 00/0", ac1, e1); end
        tests++; if (addr2 !== 8'd254) begin fails++; $display("FAIL rst_addr2 got %0d want 254", addr2); end
    endtask

    task automatic test_basic();
        clear1();
        img1[0] = 8'b0100_0100;
        img1[1] = 8'b1000_0101;
        img1[2] = 8'b0010_1000;
        img1[3] = 8'b0111_0000;
        img1[4] = 8'd3;
        img1[5] = 8'd6;
        img1[6] = 8'd4;
        start1();
        cycles(8);
        tests++; if (h1 !== 1'b0) begin fails++; $display("FAIL basic_halt_early got %b want 0", h1); end
        cycles(1);
        tests++; if (h1 !== 1'b1) begin fails++; $display("FAIL basic_halt_9 got %b want 1", h1); end
        tests++; if (ac1 !== 8'd7) begin fails++; $display("FAIL basic_ac got %h want 07", ac1); end
        tests++; if (mem1[8] !== 8'd7) begin fails++; $display("FAIL basic_m8 got %h want 07", mem1[8]); end
        tests++; if (e1 !== 1'b0) begin fails++; $display("FAIL basic_e got %b want 0", e1); end
        tests++; if (addr1 !== 4'd4) begin fails++; $display("FAIL basic_halt_addr got %h want 4", addr1); end
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            tests++; if (rd1 !== 1'b0 || wr1 !== 1'b0 || h1 !== 1'b1) begin fails++; $display("FAIL basic_quiet rd=%b wr=%b h=%b want 0 0 1", rd1, wr1, h1); end
        end
    endtask

    task automatic test_carry();
        clear1();
        img1[0]  = 8'b0100_1000;
        img1[1]  = 8'b0000_1001;
        img1[2]  = 8'b0001_1010;
        img1[3]  = 8'b0111_0000;
        img1[8]  = 8'h90;
        img1[9]  = 8'h8A;
        img1[10] = 8'h0F;
        start1();
        cycles(2);
        tests++; if (ac1 !== 8'h90) begin fails++; $display("FAIL carry_lda got %h want 90", ac1); end
        cycles(2);
        tests++; if (ac1 !== 8'h1A || e1 !== 1'b1) begin fails++; $display("FAIL carry_add got %h/%b want 1a/1", ac1, e1); end
        cycles(2);
        tests++; if (ac1 !== 8'h0A || e1 !== 1'b1) begin fails++; $display("FAIL carry_and got %h/%b want 0a/1", ac1, e1); end
        cycles(2);
        tests++; if (h1 !== 1'b1) begin fails++; $display("FAIL carry_halt got %b want 1", h1); end
    endtask

    task automatic test_sub_sza();
        clear1();
        img1[0]  = 8'b0100_1100;
        img1[1]  = 8'b0101_1101;
        img1[2]  = 8'b0110_0000;
        img1[3]  = 8'b0100_1101;
        img1[4]  = 8'b0101_1101;
        img1[5]  = 8'b0110_0000;
        img1[6]  = 8'b0100_1100;
        img1[7]  = 8'b0111_0000;
        img1[12] = 8'd5;
        img1[13] = 8'd7;
        start1();
        cycles(4);
        tests++; if (ac1 !== 8'hFE || e1 !== 1'b0) begin fails++; $display("FAIL sub_borrow got %h/%b want fe/0", ac1, e1); end
        cycles(2);
        tests++; if (addr1 !== 4'd3) begin fails++; $display("FAIL sza_noskip got %h want 3", addr1); end
        cycles(4);
        tests++; if (ac1 !== 8'h00 || e1 !== 1'b1) begin fails++; $display("FAIL sub_zero got %h/%b want 00/1", ac1, e1); end
        cycles(2);
        tests++; if (addr1 !== 4'd7) begin fails++; $display("FAIL sza_skip got %h want 7", addr1); end
        cycles(2);
        tests++; if (h1 !== 1'b1 || ac1 !== 8'h00) begin fails++; $display("FAIL sza_end got h=%b ac=%h want 1/00", h1, ac1); end
    endtask

    task automatic test_wrap_bun();
        clear1();
        img1[0]  = 8'b1011_1110;
        img1[13] = 8'h21;
        img1[14] = 8'h0F;
        img1[15] = 8'b0000_1101;
        start1();
        cycles(1);
        tests++; if (addr1 !== 4'd14 || rd1 !== 1'b1) begin fails++; $display("FAIL bun_ind_addr got %h/%b want e/1", addr1, rd1); end
        cycles(2);
        tests++; if (addr1 !== 4'd15 || rd1 !== 1'b1) begin fails++; $display("FAIL bun_target got %h/%b want f/1", addr1, rd1); end
        cycles(2);
        tests++; if (addr1 !== 4'd0 || ac1 !== 8'h21) begin fails++; $display("FAIL pc_wrap got %h ac=%h want 0 ac=21", addr1, ac1); end
    endtask

    task automatic test_reset_mid();
        clear1();
        img1[0]  = 8'b0100_1100;
        img1[1]  = 8'b1000_1101;
        img1[12] = 8'd5;
        img1[13] = 8'd14;
        img1[14] = 8'd3;
        start1();
        cycles(3);
        tests++; if (addr1 !== 4'd13) begin fails++; $display("FAIL mid_ind_pre got %h want d", addr1); end
        reset1 = 1'b1;
        #1;
        tests++; if (ac1 !== 8'h00 || addr1 !== 4'd0 || rd1 !== 1'b1) begin fails++; $display("FAIL mid_ind_rst ac=%h a=%h r=%b want 00 0 1", ac1, addr1, rd1); end
        @(negedge clk);
        reset1 = 1'b0;
        #1;
        tests++; if (addr1 !== 4'd0 || rd1 !== 1'b1) begin fails++; $display("FAIL mid_ind_refetch got %h/%b want 0/1", addr1, rd1); end
        clear1();
        img1[0]  = 8'b0100_1100;
        img1[1]  = 8'b0010_1010;
        img1[10] = 8'hAA;
        img1[12] = 8'd5;
        start1();
        cycles(3);
        tests++; if (wr1 !== 1'b1 || addr1 !== 4'd10) begin fails++; $display("FAIL mid_sta_pre wr=%b a=%h want 1 a", wr1, addr1); end
        reset1 = 1'b1;
        #1;
        tests++; if (wr1 !== 1'b0) begin fails++; $display("FAIL mid_sta_wr got %b want 0", wr1); end
        @(posedge clk);
        #1;
        tests++; if (mem1[10] !== 8'hAA || ac1 !== 8'h00) begin fails++; $display("FAIL mid_sta_mem m=%h ac=%h want aa 00", mem1[10], ac1); end
        @(negedge clk);
        reset1 = 1'b0;
        #1;
        tests++; if (addr1 !== 4'd0 || rd1 !== 1'b1) begin fails++; $display("FAIL mid_sta_refetch got %h/%b want 0/1", addr1, rd1); end
    endtask

    task automatic test_param();
        for (int i = 0; i < 256; i++) img2[i] = 12'h000;
        img2[254] = 12'h4C8;
        img2[255] = 12'h0C9;
        img2[0]   = 12'h700;
        img2[200] = 12'hFFF;
        img2[201] = 12'h001;
        reset2 = 1'b1;
        load2  = 1'b1;
        @(posedge clk);
        #1 load2 = 1'b0;
        @(negedge clk);
        reset2 = 1'b0;
        #1;
        tests++; if (addr2 !== 8'd254) begin fails++; $display("FAIL p_first got %0d want 254", addr2); end
        cycles(2);
        tests++; if (ac2 !== 12'hFFF || addr2 !== 8'd255) begin fails++; $display("FAIL p_lda ac=%h a=%0d want fff 255", ac2, addr2); end
        cycles(2);
        tests++; if (ac2 !== 12'h000 || e2 !== 1'b1) begin fails++; $display("FAIL p_add got %h/%b want 000/1", ac2, e2); end
        tests++; if (addr2 !== 8'd0) begin fails++; $display("FAIL p_wrap got %0d want 0", addr2); end
        cycles(2);
        tests++; if (h2 !== 1'b1) begin fails++; $display("FAIL p_halt got %b want 1", h2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_sub_sza();
        test_wrap_bun();
        test_reset_mid();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_acc_param.md
Name: cpu_acc_param

Overview:
- Parametrised accumulator CPU, successor to the fixed 8-bit/4-bit-address CPU2.
- Drives a single-port memory: combinational read, write on the posedge of clk.
- Generalised in data and address width; adds store, subtract, branch, skip-if-zero, halt, and a halted status output.
- Top-level core instantiated by the program benches.

Parameters:
DATA_W, 8, word width of AC, IR and memory data (must be >= ADDR_W+4; elaboration error otherwise)
ADDR_W, 4, address width of PC, AR and the memory address bus
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
read  output  1  memory read strobe
write  output  1  memory write enable, sampled by memory at posedge clk
memoryOut  input  DATA_W  read data from memory (combinational from address)
memoryIn  output  DATA_W  write data to memory (always AC)
address  output  ADDR_W  memory address
ac  output  DATA_W  accumulator, for observation
e  output  1  carry/no-borrow flag
halted  output  1  high while in HALTED state

Behaviour:
- Instruction format:
  - bit [DATA_W-1] = I (indirect).
  - bits [DATA_W-2:DATA_W-4] = opcode.
  - bits [ADDR_W-1:0] = operand address. Unused middle bits are ignored.
- Opcodes:
  - 000 ADD: {E,AC} <= AC + M.
  - 001 AND: AC <= AC & M; E unchanged.
  - 010 STA: M <= AC.
  - 011 BUN: PC <= EA.
  - 100 LDA: AC <= M; E unchanged.
  - 101 SUB: {E,AC} <= AC + ~M + 1, so E=1 means no borrow.
  - 110 SZA: if AC==0, PC <= PC+1.
  - 111 HLT.
- States: FETCH, INDIRECT, EXEC, HALTED.
- FETCH:
  - address=PC, read=1.
  - IR <= memoryOut; PC <= PC+1.
  - next = INDIRECT if memoryOut[DATA_W-1], else EXEC.
- INDIRECT:
  - address=IR[ADDR_W-1:0], read=1.
  - AR <= memoryOut[ADDR_W-1:0].
  - next EXEC.
- EXEC:
  - EA = (I ? AR : IR[ADDR_W-1:0]); address=EA.
  - read=1 for ADD/AND/LDA/SUB, else 0.
  - write=1 only for STA.
  - next FETCH, except HLT, which goes to HALTED.
- HALTED: read=0, write=0, address=PC, halted=1. Stays here until reset.
- Latency:
  - Direct instruction = 2 cycles.
  - Indirect instruction = 3 cycles.
  - Indirect applies to every opcode, including BUN and SZA; it is ignored for HLT, which still spends one extra cycle in INDIRECT.
- Width and wrap rules:
  - PC and the SZA skip wrap modulo 2^ADDR_W (PC=2^ADDR_W-1 increments to 0).
  - Arithmetic is DATA_W bits; the carry goes to E.
- reset (asynchronous, any state, including mid-INDIRECT or EXEC):
  - state=FETCH, PC=RESET_PC, AC=0, E=0, IR=0, AR=0.
  - While reset is asserted, outputs are read=1, write=0, address=RESET_PC, memoryIn=0, halted=0.
  - A write in progress is aborted, since write drops combinationally.
- read/write/address/memoryIn are combinational from state, IR, AR, PC and AC. read and write are never both 1.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams OP_ADD..OP_HLT;
  - state encoding ST_FETCH/ST_INDIRECT/ST_EXEC/ST_HALTED;
  - field-position helper constants (I bit, opcode MSB/LSB) as functions of DATA_W.
- One sub-module, cpu_alu: combinational, parametrised DATA_W, inputs opcode/AC/M, outputs result and carry.
- Sequencing, PC and memory control stay in cpu_acc_param.

Test Plan:
- Basic program (defaults):
  - Stimulus: M0=8'b0100_0100 (LDA 4), M1=8'b1000_0101 (ADD I 5), M2=8'b0010_1000 (STA 8), M3=8'b0111_0000 (HLT), M4=3, M5=6, M6=4.
  - Response: AC=7, M8=7, E=0, halted rises exactly 9 cycles after reset release, then no further read or write.
- Carry:
  - Stimulus: LDA of 8'h90, then ADD of 8'h8A.
  - Response: AC=8'h1A, E=1.
  - Follow-up: AND with 8'h0F gives AC=8'h0A with E still 1.
- SUB/SZA:
  - Stimulus: LDA 5, SUB 7.
  - Response: AC=8'hFE, E=0.
  - Follow-up: LDA 7, SUB 7 gives AC=0, E=1; the following SZA skips the next instruction (PC advances by 2), while SZA with AC!=0 does not skip.
- PC wrap/BUN:
  - Stimulus: BUN I through a pointer to 15; M15 = ADD of a constant.
  - Response: after the fetch at 15, the next fetch address is 0.
- Reset mid-operation:
  - Stimulus: assert reset during the INDIRECT cycle of ADD I, and separately during EXEC of STA.
  - Response: write deasserts immediately, target memory unchanged, AC=0; the first fetch after release is at address RESET_PC.
- Parametrised instance:
  - Stimulus: DATA_W=12, ADDR_W=8; LDA 200 (M200=12'hFFF), ADD 201 (M201=1).
  - Response: AC=0, E=1.
  - PC wrap from 255 to 0 confirmed.
